alu_op_decoder: RTL and testbench

Decode stage that turns a raw RV32I instruction word into the `alu_cntrl` / `imm_val` / `shift_amount` control bundle consumed by the ALU, plus register indices.
- Accepts instructions from fetch over a valid/ready handshake.
- Buffers decoded results in a 2-entry output queue so fetch and execute may stall independently.
- Flags and counts illegal or unsupported encodings.

---
 rtl/alu_op_decoder.sv | 194 +++++++++++++++++++
 tb/tb_alu_op_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decoder
//  Purpose  : RV32I decode stage. Turns a raw instruction word into the ALU
//             control bundle (alu_cntrl / imm_val / shift_amount) plus the
//             register indices, buffered in a 2-entry output FIFO so fetch
//             and execute can stall independently. Illegal or unsupported
//             encodings are flagged and counted.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid / in_ready / instr        - fetch side handshake
//             out_valid / out_ready              - execute side handshake
//             alu_cntrl, imm_val, shift_amount,
//             rd, rs1, rs2, illegal              - head entry of the FIFO
//             illegal_cnt                        - saturating illegal count
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       alu_cntrl,
  output logic [31:0]      imm_val,
  output logic [3:0]       shift_amount,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_F7_BASE    = 7'b0000000;
  localparam logic [6:0] C_F7_ALT     = 7'b0100000;
  localparam logic [5:0] C_ALU_ILLEGAL = 6'b111111;
  // Entry layout: {illegal, rs2, rs1, rd, shift_amount, imm_val, alu_cntrl}
  localparam int         C_ENTRY_W    = 1 + 5 + 5 + 5 + 4 + 32 + 6;

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // --------------------------------------------------------------------------
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [5:0]  w_alu;
  logic [31:0] w_imm;
  logic        w_ill;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_sh;
  logic [31:0] w_imm_b;

  assign w_opc    = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_sh = {27'b0, instr[24:20]};
  assign w_imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    w_alu = C_ALU_ILLEGAL;
    w_imm = 32'd0;
    w_ill = 1'b1;
    case (w_opc)
      C_OPC_OP: begin
        // Only the two funct7 values RV32I defines are accepted; funct7
        // selects the alternate op only for f3=000 and f3=101.
        if (w_f7 == C_F7_BASE || w_f7 == C_F7_ALT) begin
          w_ill = 1'b0;
          case (w_f3)
            3'b000:  w_alu = (w_f7 == C_F7_ALT) ? 6'b000001 : 6'b000000;
            3'b001:  w_alu = 6'b000010;
            3'b010:  w_alu = 6'b000011;
            3'b011:  w_alu = 6'b000100;
            3'b100:  w_alu = 6'b000101;
            3'b101:  w_alu = (w_f7 == C_F7_ALT) ? 6'b000111 : 6'b000110;
            3'b110:  w_alu = 6'b001000;
            default: w_alu = 6'b001001;
          endcase
        end
      end
      C_OPC_OPIMM: begin
        w_ill = 1'b0;
        w_imm = w_imm_i;
        case (w_f3)
          3'b000: w_alu = 6'b001010;
          3'b001: begin
            w_imm = w_imm_sh;
            if (w_f7 == C_F7_BASE) w_alu = 6'b001011;
            else                   w_ill = 1'b1;
          end
          3'b010: w_alu = 6'b001100;
          3'b011: w_alu = 6'b001101;
          3'b100: w_alu = 6'b001110;
          3'b101: begin
            w_imm = w_imm_sh;
            if (w_f7 == C_F7_BASE)     w_alu = 6'b001111;
            else if (w_f7 == C_F7_ALT) w_alu = 6'b000111; // SRAI shares SRA's code
            else                       w_ill = 1'b1;
          end
          3'b110:  w_alu = 6'b010000;
          default: w_alu = 6'b010001;
        endcase
      end
      C_OPC_LUI: begin
        // Raw upper-immediate; the ALU applies the shift by 12.
        w_ill = 1'b0;
        w_alu = 6'b010010;
        w_imm = {12'b0, instr[31:12]};
      end
      C_OPC_BRANCH: begin
        w_ill = 1'b0;
        w_imm = w_imm_b;
        case (w_f3)
          3'b000:  w_alu = 6'b011010;
          3'b001:  w_alu = 6'b011011;
          3'b100:  w_alu = 6'b011100;
          3'b101:  w_alu = 6'b011101;
          default: w_ill = 1'b1; // includes unsupported BLTU/BGEU
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal entries always carry a clean payload.
    if (w_ill) begin
      w_alu = C_ALU_ILLEGAL;
      w_imm = 32'd0;
    end
  end

  logic [C_ENTRY_W-1:0] w_entry;
  assign w_entry = {w_ill, instr[24:20], instr[19:15], instr[11:7], instr[23:20], w_imm, w_alu};

  // --------------------------------------------------------------------------
  // 2-entry FIFO
  // --------------------------------------------------------------------------
  logic [C_ENTRY_W-1:0] r_mem [2];
  logic                 r_head;
  logic                 r_tail;
  logic [1:0]           r_count;
  logic [CNT_W-1:0]     r_ill_cnt;
  logic                 w_push;
  logic                 w_pop;
  logic [C_ENTRY_W-1:0] w_head;

  // Ready depends on occupancy only, so there is no out_ready -> in_ready path.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_count   <= 2'd0;
      r_ill_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_entry;
        r_tail        <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_ill && (r_ill_cnt != {CNT_W{1'b1}}))
        r_ill_cnt <= r_ill_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Data outputs read as zero whenever the queue is empty.
  assign w_head       = out_valid ? r_mem[r_head] : '0;
  assign alu_cntrl    = w_head[5:0];
  assign imm_val      = w_head[37:6];
  assign shift_amount = w_head[41:38];
  assign rd           = w_head[46:42];
  assign rs1          = w_head[51:47];
  assign rs2          = w_head[56:52];
  assign illegal      = w_head[57];
  assign illegal_cnt  = r_ill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_decoder
//  Purpose  : Self-checking bench for alu_op_decoder: directed scenarios with
//             literal expectations plus randomized traffic compared every
//             cycle against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_decoder;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       alu_cntrl;
  logic [31:0]      imm_val;
  logic [3:0]       shift_amount;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  alu_op_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_cntrl(alu_cntrl), .imm_val(imm_val), .shift_amount(shift_amount),
    .rd(rd), .rs1(rs1), .rs2(rs2), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: table-driven decode from the RV32I field rules
  // --------------------------------------------------------------------------
  typedef struct {
    logic [5:0]  alu;
    logic [31:0] imm;
    logic [3:0]  sh;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ill;
  } exp_t;

  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    int op, f3, f7, v;
    int rtab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int itab[8] = '{10, 11, 12, 13, 14, 15, 16, 17};
    int btab[8] = '{26, 27, -1, -1, 28, 29, -1, -1};
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    e.sh = w[23:20]; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.ill = 1'b1; e.alu = 6'd63; e.imm = 0;
    if (op == 51 && (f7 == 0 || f7 == 32)) begin
      v = rtab[f3];
      if (f7 == 32 && (f3 == 0 || f3 == 5)) v = v + 1;
      e.alu = 6'(v); e.ill = 1'b0;
    end else if (op == 19) begin
      if (f3 == 1 || f3 == 5) begin
        if (f7 == 0) begin e.alu = 6'(itab[f3]); e.ill = 1'b0; end
        else if (f7 == 32 && f3 == 5) begin e.alu = 6'd7; e.ill = 1'b0; end
        if (!e.ill) e.imm = int'(w[24:20]);
      end else begin
        v = int'(w[31:20]);
        if (v >= 2048) v = v - 4096;
        e.alu = 6'(itab[f3]); e.imm = v; e.ill = 1'b0;
      end
    end else if (op == 55) begin
      e.alu = 6'd18; e.imm = int'(w[31:12]); e.ill = 1'b0;
    end else if (op == 99 && btab[f3] >= 0) begin
      v = 2 * int'({w[31], w[7], w[30:25], w[11:8]});
      if (v >= 4096) v = v - 8192;
      e.alu = 6'(btab[f3]); e.imm = v; e.ill = 1'b0;
    end
    return e;
  endfunction

  exp_t q[$];
  int   mcnt = 0;

  // Every-cycle comparison at the falling edge, then advance the model with
  // the handshakes that the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst illegal_cnt", 32'(illegal_cnt), 32'd0);
    end else begin
      bit push, pop;
      exp_t e;
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
      if (q.size() > 0 && out_valid) begin
        chk("alu_cntrl", 32'(alu_cntrl), 32'(q[0].alu));
        chk("imm_val", imm_val, q[0].imm);
        chk("shift_amount", 32'(shift_amount), 32'(q[0].sh));
        chk("rd", 32'(rd), 32'(q[0].rd));
        chk("rs1", 32'(rs1), 32'(q[0].rs1));
        chk("rs2", 32'(rs2), 32'(q[0].rs2));
        chk("illegal", 32'(illegal), 32'(q[0].ill));
      end
      push = in_valid && (q.size() < 2);
      pop  = out_ready && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (push) begin
        e = ref_dec(instr);
        q.push_back(e);
        if (e.ill && mcnt < (1 << CNT_W) - 1) mcnt++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic push(input logic [31:0] w);
    bit done = 0;
    in_valid = 1'b1;
    instr    = w;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("push timeout", 32'd0, 32'd1);
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_head(input string name, input logic [5:0] alu, input logic [31:0] imm, input logic ill);
    chk({name, " valid"}, 32'(out_valid), 32'd1);
    chk({name, " alu"}, 32'(alu_cntrl), 32'(alu));
    chk({name, " imm"}, imm_val, imm);
    chk({name, " illegal"}, 32'(illegal), 32'(ill));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 5);
    case (sel)
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h37;
      3: r[6:0] = 7'h63;
      4: ;
      default: r = 32'd0;
    endcase
    if (sel <= 1) begin
      case ($urandom_range(0, 3))
        0, 1: r[31:25] = 7'h00;
        2:    r[31:25] = 7'h20;
        default: ;
      endcase
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Directed scenarios, then randomized traffic
  // --------------------------------------------------------------------------
  initial begin
    logic [CNT_W-1:0] cnt_exp [5];
    cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADDI x1,x0,5 with out_ready high: one-cycle latency to the head.
    out_ready = 1'b1;
    push(32'h00500093);
    chk_head("addi", 6'b001010, 32'd5, 1'b0);
    chk("addi rd", 32'(rd), 32'd1);
    chk("addi rs1", 32'(rs1), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drained", 32'(out_valid), 32'd0);

    // SUB then LUI back-to-back, delivered in order.
    push(32'h402081B3);
    push(32'h123452B7);
    chk_head("sub", 6'b000001, 32'd0, 1'b0);
    chk("sub rd", 32'(rd), 32'd3);
    chk("sub rs1", 32'(rs1), 32'd1);
    chk("sub rs2", 32'(rs2), 32'd2);
    pop1();
    chk_head("lui", 6'b010010, 32'h00012345, 1'b0);
    chk("lui rd", 32'(rd), 32'd5);
    pop1();

    // BEQ with negative offset, then unsupported BLTU.
    push(32'hFE208EE3);
    chk_head("beq", 6'b011010, 32'hFFFFFFFC, 1'b0);
    pop1();
    push(32'hFE20EEE3);
    chk_head("bltu", 6'b111111, 32'd0, 1'b1);
    chk("bltu cnt", 32'(illegal_cnt), 32'd1);
    pop1();

    // Backpressure: third offer waits until the queue drains.
    in_valid = 1'b1; instr = 32'h00500093;
    @(posedge clk); #1;
    instr = 32'h402081B3;
    @(posedge clk); #1;
    chk("full in_ready", 32'(in_ready), 32'd0);
    instr = 32'h123452B7;
    for (int i = 0; i < 3; i++) begin
      chk_head("stall head", 6'b001010, 32'd5, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_head("drain b", 6'b000001, 32'd0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_head("drain c", 6'b010010, 32'h00012345, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain empty", 32'(out_valid), 32'd0);

    // Saturating illegal counter.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(32'h00000000);
      chk("zero illegal", 32'(illegal), 32'd1);
      chk("zero cnt", 32'(illegal_cnt), 32'(cnt_exp[k]));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset with a full queue.
    do_reset();
    push(32'h00000000);
    push(32'h00500093);
    chk("pre-rst full", 32'(in_ready), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async in_ready", 32'(in_ready), 32'd1);
    chk("async alu", 32'(alu_cntrl), 32'd0);
    chk("async illegal", 32'(illegal), 32'd0);
    chk("async cnt", 32'(illegal_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(32'h00500093);
    chk_head("post-rst", 6'b001010, 32'd5, 1'b0);
    pop1();

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
